serial_subtractor: RTL

Bit-serial, multi-cycle 8-bit subtractor: accepts operands on a start pulse, computes `a - b` one bit per clock through a single full-subtractor cell, and presents the difference and final borrow with a one-cycle `done` strobe. It is the inverse companion of the team's registered adder and sits beside it in the arithmetic lab datapath, trading latency for a 1-bit datapath.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: sequencer state encoding and default datapath width.
package arith_pkg;

  localparam int unsigned ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b using one full-subtractor cell, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SATURATE_EN clamps the difference to 0 when a < b.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             borrow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             diff, bout;

  full_subtractor u_fs (
    .x    (a_q[cnt_q]),
    .y    (b_q[cnt_q]),
    .bin  (bin_q),
    .d    (diff),
    .bout (bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        c_d   = {diff, c_q[WIDTH-1:1]};
        bin_d = bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          borrow_d = bout;
          done_d   = 1'b1;
          state_d  = StDone;
`ifdef SERIAL_SUB_SATURATE_EN
          if (bout) begin
            c_d = '0;
          end
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = done_q;
    c      = c_q;
    borrow = borrow_q;
  end

endmodule
